// File: rtl/pipe_stage_latch_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_latch_if
// Handshake and payload bundle around one pipeline stage register.
//
// Signals
//   in_valid  / in_ready   upstream valid/ready pair (beat moves when both are 1)
//   in_pc     / in_data    upstream payload, sampled by the stage on an accepted beat
//   out_valid / out_ready  downstream valid/ready pair
//   out_pc    / out_data   payload currently held by the stage
//
// Modports
//   master  environment side: drives upstream beats and downstream acceptance
//   slave   stage side: accepts upstream beats and presents the held entry
// -----------------------------------------------------------------------------
interface pipe_stage_latch_if #(
    parameter int PC_WIDTH   = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PC_WIDTH-1:0]   in_pc;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_pc, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_data
    );

    modport slave (
        input  in_valid, in_pc, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_data
    );
endinterface

// File: rtl/pipe_stage_latch.sv
// -----------------------------------------------------------------------------
// pipe_stage_latch
// Generic LC-3b pipeline stage register carrying a PC and an instruction/data
// word between two stages, with valid/ready handshake, backpressure stall,
// synchronous flush (bubble insertion) and an optional two-entry skid buffer.
//
// Parameters
//   PC_WIDTH    width of the PC field
//   DATA_WIDTH  width of the instruction/data field
//   NOP_WORD    value presented on out_data whenever no valid entry is held
//   SKID        0: single entry, in_ready combinational from out_ready
//               1: two entries (MAIN + SKIDREG), in_ready fully registered
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset; held entries are lost
//   flush      synchronous discard of all entries and of a same-cycle input beat
//   bus        pipe_stage_latch_if.slave (upstream and downstream handshake)
//   occupancy  number of valid entries held (0..1 or 0..2)
// -----------------------------------------------------------------------------
module pipe_stage_latch #(
    parameter int                    PC_WIDTH   = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = {DATA_WIDTH{1'b0}},
    parameter bit                    SKID       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_latch_if.slave bus,
    output logic [1:0]        occupancy
);

    // FULL is only reachable with the skid slot present: with SKID=0 an
    // accepted beat in ONE always coincides with the held beat leaving.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_IDLE = {PC_WIDTH{1'b0}};

    // Entry count implied by a state; kept as a function so the count can
    // never drift from the state encoding.
    function automatic logic [1:0] occ_of(input state_e st);
        case (st)
            ST_EMPTY: occ_of = 2'd0;
            ST_ONE:   occ_of = 2'd1;
            ST_FULL:  occ_of = 2'd2;
            default:  occ_of = 2'd0;
        endcase
    endfunction

    state_e                state_q;
    state_e                state_d;
    logic [PC_WIDTH-1:0]   main_pc_q;
    logic [PC_WIDTH-1:0]   main_pc_d;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic [DATA_WIDTH-1:0] main_data_d;
    logic [PC_WIDTH-1:0]   skid_pc_q;
    logic [PC_WIDTH-1:0]   skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [DATA_WIDTH-1:0] skid_data_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  in_ready_q;
    logic                  in_ready_d;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;

    logic                  in_ready_s;
    logic                  in_fire_s;
    logic                  out_fire_s;

    // With the skid slot the ready flag comes straight from a flop; without it
    // the single register may refill in the same cycle it drains.
    assign in_ready_s = SKID ? in_ready_q : (~out_valid_q | bus.out_ready);
    assign in_fire_s  = bus.in_valid & in_ready_s;
    assign out_fire_s = out_valid_q & bus.out_ready;

    // MAIN is forced to PC_IDLE/NOP_WORD whenever the stage empties, so the
    // visible payload is a plain register read with no output mux.
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = main_pc_q;
    assign bus.out_data  = main_data_q;
    assign occupancy     = occ_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every handshake outcome.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        state_d = ST_FULL;
                    end else if (!in_fire_s && out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Output logic: payload slot updates plus flag values for the next state.
    always_comb begin
        main_pc_d   = main_pc_q;
        main_data_d = main_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_pc_d   = PC_IDLE;
            main_data_d = NOP_WORD;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_pc_d   = bus.in_pc;
                        main_data_d = bus.in_data;
                    end else begin
                        main_pc_d   = PC_IDLE;
                        main_data_d = NOP_WORD;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_pc_d   = bus.in_pc;
                        main_data_d = bus.in_data;
                    end else if (out_fire_s) begin
                        main_pc_d   = PC_IDLE;
                        main_data_d = NOP_WORD;
                    end else if (in_fire_s) begin
                        // MAIN is still waiting downstream; park the new beat
                        // behind it so order is preserved.
                        skid_pc_d   = bus.in_pc;
                        skid_data_d = bus.in_data;
                    end else begin
                        main_pc_d   = main_pc_q;
                        main_data_d = main_data_q;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        main_pc_d   = skid_pc_q;
                        main_data_d = skid_data_q;
                    end else begin
                        main_pc_d   = main_pc_q;
                        main_data_d = main_data_q;
                    end
                end
                default: begin
                    main_pc_d   = PC_IDLE;
                    main_data_d = NOP_WORD;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        occ_d       = occ_of(state_d);
    end

    // Payload and flag registers; in_ready resets low and rises on the first
    // edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_pc_q   <= PC_IDLE;
            main_data_q <= NOP_WORD;
            skid_pc_q   <= PC_IDLE;
            skid_data_q <= NOP_WORD;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            main_pc_q   <= main_pc_d;
            main_data_q <= main_data_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_latch
// Drives three stage instances (SKID=1 16-bit, SKID=0 16-bit, SKID=1 32-bit
// with a non-zero NOP word) one at a time and compares every cycle against a
// FIFO reference: a queue with capacity 2 (skid) or 1 (single register).
// -----------------------------------------------------------------------------
module tb_pipe_stage_latch;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]  sel       = 2'd0;
    logic        drv_valid = 1'b0;
    logic [31:0] drv_pc    = 32'd0;
    logic [31:0] drv_data  = 32'd0;
    logic        drv_ordy  = 1'b0;

    logic        obs_valid;
    logic        obs_ready;
    logic [31:0] obs_pc;
    logic [31:0] obs_data;
    logic [1:0]  obs_occ;

    logic [1:0]  occ_s;
    logic [1:0]  occ_r;
    logic [1:0]  occ_w;

    pipe_stage_latch_if #(.PC_WIDTH(16), .DATA_WIDTH(16)) if_s ();
    pipe_stage_latch_if #(.PC_WIDTH(16), .DATA_WIDTH(16)) if_r ();
    pipe_stage_latch_if #(.PC_WIDTH(32), .DATA_WIDTH(32)) if_w ();

    assign if_s.in_valid  = drv_valid && (sel == 2'd0);
    assign if_s.in_pc     = drv_pc[15:0];
    assign if_s.in_data   = drv_data[15:0];
    assign if_s.out_ready = drv_ordy;
    assign if_r.in_valid  = drv_valid && (sel == 2'd1);
    assign if_r.in_pc     = drv_pc[15:0];
    assign if_r.in_data   = drv_data[15:0];
    assign if_r.out_ready = drv_ordy;
    assign if_w.in_valid  = drv_valid && (sel == 2'd2);
    assign if_w.in_pc     = drv_pc;
    assign if_w.in_data   = drv_data;
    assign if_w.out_ready = drv_ordy;

    pipe_stage_latch #(.PC_WIDTH(16), .DATA_WIDTH(16), .NOP_WORD(16'h0000), .SKID(1'b1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush), .bus(if_s), .occupancy(occ_s));
    pipe_stage_latch #(.PC_WIDTH(16), .DATA_WIDTH(16), .NOP_WORD(16'h0000), .SKID(1'b0)) u_reg (
        .clk(clk), .reset(reset), .flush(flush), .bus(if_r), .occupancy(occ_r));
    pipe_stage_latch #(.PC_WIDTH(32), .DATA_WIDTH(32), .NOP_WORD(32'hDEADBEEF), .SKID(1'b1)) u_wide (
        .clk(clk), .reset(reset), .flush(flush), .bus(if_w), .occupancy(occ_w));

    // Route the selected instance to the common observation signals.
    always_comb begin
        case (sel)
            2'd0: begin
                obs_valid = if_s.out_valid;  obs_ready = if_s.in_ready;
                obs_pc    = {16'h0000, if_s.out_pc};
                obs_data  = {16'h0000, if_s.out_data};
                obs_occ   = occ_s;
            end
            2'd1: begin
                obs_valid = if_r.out_valid;  obs_ready = if_r.in_ready;
                obs_pc    = {16'h0000, if_r.out_pc};
                obs_data  = {16'h0000, if_r.out_data};
                obs_occ   = occ_r;
            end
            2'd2: begin
                obs_valid = if_w.out_valid;  obs_ready = if_w.in_ready;
                obs_pc    = if_w.out_pc;
                obs_data  = if_w.out_data;
                obs_occ   = occ_w;
            end
            default: begin
                obs_valid = 1'b0; obs_ready = 1'b0;
                obs_pc = 32'd0; obs_data = 32'd0; obs_occ = 2'd0;
            end
        endcase
    end

    // Reference model: ordered queue of {pc, data} entries.
    logic [63:0] q[$];
    logic        m_skid    = 1'b1;
    logic [31:0] m_nop     = 32'd0;
    logic [31:0] m_pcmask  = 32'h0000FFFF;
    logic [31:0] m_dmask   = 32'h0000FFFF;
    logic        m_rdy     = 1'b0;
    logic        m_rdy_ok  = 1'b0;
    string       phase     = "init";

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic set_dut(input logic [1:0] s, input logic skid, input logic [31:0] nop,
                           input logic [31:0] pcm, input logic [31:0] dm, input string name);
        sel = s; m_skid = skid; m_nop = nop; m_pcmask = pcm; m_dmask = dm; phase = name;
    endtask

    // One clock: apply inputs, check pre-edge outputs at the falling edge,
    // then advance the model across the rising edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] d,
                       input logic ordy, input logic fl);
        logic [63:0] head;
        logic        exp_rdy;
        logic        ifire;
        logic        ofire;
        drv_valid = v; drv_pc = pc; drv_data = d; drv_ordy = ordy; flush = fl;
        @(negedge clk);
        if (q.size() != 0) begin
            head = q[0];
            chk("out_valid", {31'd0, obs_valid}, 32'd1);
            chk("out_pc",    obs_pc,   head[63:32]);
            chk("out_data",  obs_data, head[31:0]);
        end else begin
            chk("out_valid", {31'd0, obs_valid}, 32'd0);
            chk("out_pc",    obs_pc,   32'd0);
            chk("out_data",  obs_data, m_nop);
        end
        chk("occupancy", {30'd0, obs_occ}, 32'(q.size()));
        if (m_skid) begin
            exp_rdy = m_rdy;
        end else begin
            exp_rdy = (q.size() == 0) || ordy;
        end
        if (m_rdy_ok || !m_skid) begin
            chk("in_ready", {31'd0, obs_ready}, {31'd0, exp_rdy});
        end
        ifire = v && exp_rdy;
        ofire = (q.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back({pc & m_pcmask, d & m_dmask});
        end
        m_rdy    = (q.size() < 2);
        m_rdy_ok = 1'b1;
        #1;
    endtask

    // Partial-cycle asynchronous reset pulse between two clock edges.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, obs_valid}, 32'd0);
        chk("rst_out_pc",    obs_pc,   32'd0);
        chk("rst_out_data",  obs_data, m_nop);
        chk("rst_occupancy", {30'd0, obs_occ}, 32'd0);
        #1 reset = 1'b0;
        q.delete();
        m_rdy = 1'b0; m_rdy_ok = 1'b0;
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clk); #1;

        // Reset mid-operation on a FULL skid stage.
        set_dut(2'd0, 1'b1, 32'd0, 32'h0000FFFF, 32'h0000FFFF, "reset");
        do_reset();
        cyc(1'b1, 32'h3000, 32'h1234, 1'b0, 1'b0);
        cyc(1'b1, 32'h3002, 32'h5678, 1'b0, 1'b0);
        chk("full_occ", {30'd0, obs_occ}, 32'd2);
        do_reset();
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Streaming at full rate.
        phase = "stream";
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h3000 + 32'(2 * i), 32'hA000 + 32'(i), 1'b1, 1'b0);
        end
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Backpressure into the skid slot, then drain.
        phase = "skid";
        cyc(1'b1, 32'h3010, 32'h00A0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3012, 32'h00A1, 1'b0, 1'b0);
        cyc(1'b1, 32'h3014, 32'h00A2, 1'b0, 1'b0);
        cyc(1'b1, 32'h3014, 32'h00A2, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush a FULL stage with a same-cycle input beat.
        phase = "flush";
        cyc(1'b1, 32'h3020, 32'h00A0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3022, 32'h00A1, 1'b0, 1'b0);
        cyc(1'b1, 32'h3024, 32'h00A2, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Random traffic on the skid stage.
        phase = "rand_skid";
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Single-register pass-through.
        set_dut(2'd1, 1'b0, 32'd0, 32'h0000FFFF, 32'h0000FFFF, "single");
        do_reset();
        cyc(1'b1, 32'h3100, 32'h00B0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3102, 32'h00B1, 1'b0, 1'b0);
        cyc(1'b1, 32'h3104, 32'h00B2, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        phase = "rand_single";
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Wide instance with a non-zero NOP word.
        set_dut(2'd2, 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF, "wide");
        do_reset();
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, 32'h8000_0000, 32'h1234_5678, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        phase = "rand_wide";
        for (int i = 0; i < 100; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
- Parametrised successor to the fixed IF/ID latch; generic pipeline stage register carrying a PC and an instruction/data word between any two LC-3b pipeline stages.
- Adds a valid/ready handshake, stall via backpressure, synchronous flush with bubble (NOP) insertion, and an optional two-entry skid buffer.
- With the skid buffer enabled, in_ready is fully registered, so no combinational path runs from out_ready to in_ready.

Parameters:
PC_WIDTH, 16, width of the PC field
DATA_WIDTH, 16, width of the instruction/data field
NOP_WORD, 16'h0000 (DATA_WIDTH bits), value driven on out_data when the stage holds no valid entry
SKID, 1, 0 = single-entry register with combinational ready; 1 = two-entry skid buffer with registered ready

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of all held entries and of any same-cycle input beat
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_pc  input  PC_WIDTH  upstream PC
in_data  input  DATA_WIDTH  upstream instruction/data
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_pc  output  PC_WIDTH  held PC
out_data  output  DATA_WIDTH  held instruction/data; NOP_WORD when out_valid=0
occupancy  output  2  number of entries held (0..1 when SKID=0, 0..2 when SKID=1)

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_pc and in_data are sampled only on in_fire.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, out_pc=0, out_data=NOP_WORD, occupancy=0.
  - Held entries are lost.
  - in_ready=1 from the first clock edge after reset deasserts.
- Flush:
  - Highest priority after reset.
  - On the edge where flush=1: all entries are dropped, and the next state is EMPTY regardless of in_fire or out_fire.
  - The same-cycle input beat is discarded.
  - A same-cycle out_fire still counts as consumed downstream.
  - In the following cycle: out_valid=0, out_data=NOP_WORD, out_pc=0, in_ready=1.
- SKID=0 (single register):
  - in_ready = ~out_valid | out_ready (combinational).
  - On in_fire, the register loads in_pc and in_data, and out_valid=1 next cycle (latency 1).
  - On out_fire without in_fire: out_valid=0 next cycle.
  - Simultaneous in_fire and out_fire: the register reloads with the new beat and out_valid stays 1.
- SKID=1 (states EMPTY, ONE, FULL; two storage slots, MAIN and SKIDREG):
  - in_ready is registered: 1 in EMPTY/ONE, 0 in FULL.
  - out_valid = (state != EMPTY).
  - out_pc and out_data come from MAIN.
  - Transitions:
    - EMPTY: in_fire -> ONE, MAIN<=in.
    - ONE:
      - in_fire & out_fire -> ONE, MAIN<=in.
      - in_fire only -> FULL, SKIDREG<=in.
      - out_fire only -> EMPTY.
      - neither -> ONE (hold).
    - FULL: out_fire -> ONE, MAIN<=SKIDREG; otherwise hold. No input is accepted while FULL.
  - Order is strictly preserved; no beat is duplicated or dropped except by flush or reset.
- Latency: one cycle from in_fire to out_valid in both modes. Throughput: one beat per cycle with out_ready held high.
- Held outputs:
  - While out_valid=1 and out_ready=0, out_pc and out_data are stable.
  - While out_valid=0, out_data=NOP_WORD and out_pc=0.
- occupancy always equals the number of held valid entries, updated on the same edge as the state.
- No arithmetic is performed on the payload. Widths pass through unchanged.

Test Plan:
- Reset mid-operation: load pc=16'h3000, data=16'h1234 into a FULL stage (SKID=1), then assert reset for a partial cycle -> immediately out_valid=0, out_data=16'h0000, occupancy=0; in_ready=1 after the first edge following deassertion.
- Streaming: SKID=1, out_ready=1, present beats pc=16'h3000..16'h3006 step 2, data=16'hA000..16'hA003, one per cycle -> each appears exactly one cycle later, in order, with in_ready held at 1 and occupancy=1.
- Backpressure/skid: out_ready=0, send data A0 then A1 -> occupancy 1 then 2, in_ready=0 in the cycle after A1 is accepted, out_data stable at A0; then raise out_ready -> A0 and A1 emerge on consecutive cycles and in_ready returns to 1 one cycle after leaving FULL.
- Flush with simultaneous input: FULL with A0 and A1, assert flush with in_valid=1 and data=A2 -> next cycle out_valid=0, out_data=NOP_WORD, occupancy=0; A2 never appears at the output.
- SKID=0 pass-through: out_ready=0 with one entry held -> in_ready=0; raise out_ready with in_valid=1 in the same cycle -> in_ready=1 combinationally, the new beat replaces the old one, and out_valid stays 1.
- Custom parameters: PC_WIDTH=32, DATA_WIDTH=32, NOP_WORD=32'hDEADBEEF, idle -> out_data=32'hDEADBEEF; pc=32'h8000_0000 passes through unchanged.
